// File: rtl/fetch_pkg.sv
// Shared fetch front-end definitions: default widths, the bundle record and
// the flush-source encoding used by fetch_queue_unit.
package fetch_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INST_W_DEF  = 16;
  localparam int FETCH_W_DEF = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]                      pc;
    logic [FETCH_W_DEF-1:0][INST_W_DEF-1:0]   inst;
  } fetch_bundle_t;

  // Highest-priority active redirect source in a given cycle.
  typedef enum logic [1:0] {
    FLUSH_NONE       = 2'd0,
    FLUSH_REDIRECT   = 2'd1,
    FLUSH_MISPREDICT = 2'd2,
    FLUSH_EXTERNAL   = 2'd3
  } flush_src_e;

  function automatic logic is_full_flush(flush_src_e src);
    return (src == FLUSH_MISPREDICT) || (src == FLUSH_EXTERNAL);
  endfunction

endpackage

// File: rtl/fetch_bundle_fifo.sv
// Power-of-two bundle FIFO with synchronous flush, occupancy count and a
// head output that reads zero when empty.
module fetch_bundle_fifo #(
  parameter int DW    = 80,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [DW-1:0]                push_data_i,
  input  logic                         pop_i,
  output logic [DW-1:0]                head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  // Push at full is only accepted when the head leaves in the same cycle.
  assign pop_ok  = pop_i & (count_q != '0);
  assign push_ok = push_i & ((count_q != CW'(DEPTH)) | pop_ok);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_ok)  head_d = head_q + AW'(1);
      if (push_ok) tail_d = tail_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[tail_q] <= push_data_i;
  end

  assign head_o  = (count_q == '0) ? '0 : mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Sequential fetch generator with credit-limited imem requests, epoch-tagged
// responses and a bundle queue toward decode. FETCH_EXT_PC_EN adds an external PC load.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter int              FETCH_W  = FETCH_W_DEF,
  parameter int              QDEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          has_mispredict,
  input  logic [PC_W-1:0]               pc_recovery,
  input  logic                          redirect_vld,
  input  logic [PC_W-1:0]               redirect_pc,
`ifdef FETCH_EXT_PC_EN
  input  logic                          exter_pc_en,
  input  logic [PC_W-1:0]               exter_pc,
`endif
  output logic                          imem_req,
  output logic [PC_W-1:0]               imem_addr,
  input  logic [FETCH_W*INST_W-1:0]     imem_rdata,
  output logic                          dec_vld,
  input  logic                          dec_rdy,
  output logic [PC_W-1:0]               dec_pc,
  output logic [FETCH_W*INST_W-1:0]     dec_inst,
  output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam int BW = FETCH_W * INST_W;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic            epoch_q, epoch_d;

  flush_src_e      flush_src;
  logic [PC_W-1:0] flush_pc;
  logic            flush, full_flush;
  logic [CW:0]     occupancy;
  logic            credit_ok, rsp_ok, pop;
  logic [PC_W+BW-1:0] head;

  always_comb begin
    flush_src = FLUSH_NONE;
    flush_pc  = redirect_pc;
`ifdef FETCH_EXT_PC_EN
    if (exter_pc_en) begin
      flush_src = FLUSH_EXTERNAL;
      flush_pc  = exter_pc;
    end else
`endif
    if (has_mispredict) begin
      flush_src = FLUSH_MISPREDICT;
      flush_pc  = pc_recovery;
    end else if (redirect_vld) begin
      flush_src = FLUSH_REDIRECT;
    end
  end

  assign flush      = (flush_src != FLUSH_NONE);
  assign full_flush = is_full_flush(flush_src);

  // A same-cycle dequeue is not credited back, so the queue can never overflow.
  assign occupancy = {1'b0, q_count} + (CW+1)'(inflight_q);
  assign credit_ok = occupancy < (CW+1)'(QDEPTH);
  assign imem_req  = rst_n & credit_ok & ~flush;
  assign imem_addr = pc_q;

  assign rsp_ok = inflight_q & (inflight_epoch_q == epoch_q) & ~flush;
  assign pop    = dec_vld & dec_rdy;

  always_comb begin
    pc_d             = pc_q;
    epoch_d          = epoch_q ^ flush;
    inflight_d       = imem_req;
    inflight_epoch_d = inflight_epoch_q;
    req_pc_d         = req_pc_q;
    if (flush) begin
      pc_d = flush_pc;
    end else if (imem_req) begin
      pc_d             = pc_q + PC_W'(FETCH_W);
      inflight_epoch_d = epoch_q;
      req_pc_d         = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      req_pc_q         <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      req_pc_q         <= req_pc_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  fetch_bundle_fifo #(
    .DW    (PC_W + BW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (full_flush),
    .push_i      (rsp_ok),
    .push_data_i ({req_pc_q, imem_rdata}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (q_count)
  );

  assign dec_vld  = (q_count != '0);
  assign dec_pc   = head[BW +: PC_W];
  assign dec_inst = head[BW-1:0];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int PC_W    = 16;
  localparam int INST_W  = 16;
  localparam int FETCH_W = 4;
  localparam int QDEPTH  = 4;
  localparam int BW      = FETCH_W * INST_W;
  localparam int CW      = $clog2(QDEPTH + 1);
`ifdef FETCH_EXT_PC_EN
  localparam bit EXT_EN  = 1'b1;
`else
  localparam bit EXT_EN  = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            has_mispredict;
  logic [PC_W-1:0] pc_recovery;
  logic            redirect_vld;
  logic [PC_W-1:0] redirect_pc;
  logic            extDrv;
  logic [PC_W-1:0] epcDrv;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [BW-1:0]   imem_rdata;
  logic            dec_vld;
  logic            dec_rdy;
  logic [PC_W-1:0] dec_pc;
  logic [BW-1:0]   dec_inst;
  logic [CW-1:0]   q_count;

  int testsRun    = 0;
  int testsFailed = 0;

  fetch_queue_unit #(
    .PC_W     (PC_W),
    .INST_W   (INST_W),
    .FETCH_W  (FETCH_W),
    .QDEPTH   (QDEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .has_mispredict (has_mispredict),
    .pc_recovery    (pc_recovery),
    .redirect_vld   (redirect_vld),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_EXT_PC_EN
    .exter_pc_en    (extDrv),
    .exter_pc       (epcDrv),
`endif
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .dec_vld        (dec_vld),
    .dec_rdy        (dec_rdy),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst),
    .q_count        (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each instruction word is its own address tagged with a constant.
  function automatic logic [BW-1:0] tagData(input logic [PC_W-1:0] a);
    logic [BW-1:0] r;
    for (int i = 0; i < FETCH_W; i++) r[i*INST_W +: INST_W] = (a + 16'(i)) ^ 16'h5A00;
    return r;
  endfunction

  // Fixed one-cycle instruction memory.
  logic [PC_W-1:0] memAddr = '0;
  always @(posedge clk) if (imem_req) memAddr <= imem_addr;
  assign imem_rdata = tagData(memAddr);

  // Reference model: queue of bundle PCs, one pending response, next fetch PC.
  logic [PC_W-1:0] mQ[$];
  logic [PC_W-1:0] mPc;
  logic [PC_W-1:0] mPendPc;
  bit              mPendValid;

  task automatic modelReset();
    mQ.delete();
    mPc        = 16'h0000;
    mPendPc    = '0;
    mPendValid = 1'b0;
  endtask

  function automatic bit modelFull();
    return (EXT_EN && extDrv) || has_mispredict;
  endfunction

  function automatic bit modelFlush();
    return modelFull() || redirect_vld;
  endfunction

  function automatic bit modelReq();
    return !modelFlush() && ((mQ.size() + int'(mPendValid)) < QDEPTH);
  endfunction

  task automatic modelStep();
    bit req;
    bit popv;
    req  = modelReq();
    popv = (mQ.size() > 0) && dec_rdy;
    if (modelFull()) mQ.delete();
    else begin
      if (popv) void'(mQ.pop_front());
      if (mPendValid && !modelFlush()) mQ.push_back(mPendPc);
    end
    mPendValid = req;
    mPendPc    = mPc;
    if (EXT_EN && extDrv)   mPc = epcDrv;
    else if (has_mispredict) mPc = pc_recovery;
    else if (redirect_vld)   mPc = redirect_pc;
    else if (req)            mPc = mPc + 16'(FETCH_W);
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rdy, input bit mis, input logic [PC_W-1:0] rec,
                               input bit red, input logic [PC_W-1:0] rpc,
                               input bit ext, input logic [PC_W-1:0] epc);
    dec_rdy        = rdy;
    has_mispredict = mis;
    pc_recovery    = rec;
    redirect_vld   = red;
    redirect_pc    = rpc;
    extDrv         = ext;
    epcDrv         = epc;
  endtask

  task automatic checkOutput();
    #1;
    checkVal("imem_req",  64'(imem_req),  64'(modelReq()));
    checkVal("imem_addr", 64'(imem_addr), 64'(mPc));
    checkVal("dec_vld",   64'(dec_vld),   64'(mQ.size() > 0));
    checkVal("dec_pc",    64'(dec_pc),    (mQ.size() > 0) ? 64'(mQ[0]) : 64'd0);
    checkVal("dec_inst",  64'(dec_inst),  (mQ.size() > 0) ? 64'(tagData(mQ[0])) : 64'd0);
    checkVal("q_count",   64'(q_count),   64'(mQ.size()));
  endtask

  task automatic advance();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runCycle(input bit rdy, input bit mis, input logic [PC_W-1:0] rec,
                          input bit red, input logic [PC_W-1:0] rpc,
                          input bit ext, input logic [PC_W-1:0] epc);
    applyStimulus(rdy, mis, rec, red, rpc, ext, epc);
    checkOutput();
    advance();
  endtask

  typedef struct {
    bit              rdy;
    bit              mis;
    logic [PC_W-1:0] rec;
    bit              red;
    logic [PC_W-1:0] rpc;
    bit              eReq;
    logic [PC_W-1:0] eAddr;
    bit              eVld;
    logic [PC_W-1:0] ePc;
    int              eCnt;
  } vec_t;

  vec_t tab[$];

  initial begin
    // Normal flow, stall until full, drain, mispredict with 3 queued, redirect over in-flight.
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000, 0});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 1, 16'h0000, 1});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h000C, 1, 16'h0004, 1});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 1, 16'h0008, 1});
    tab.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0014, 1, 16'h000C, 1});
    tab.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0018, 1, 16'h000C, 2});
    tab.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h001C, 1, 16'h000C, 3});
    tab.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h001C, 1, 16'h000C, 4});
    tab.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h001C, 1, 16'h000C, 4});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 0, 16'h001C, 1, 16'h000C, 4});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h001C, 1, 16'h0010, 3});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 1, 16'h0014, 2});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0024, 1, 16'h0018, 2});
    tab.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0028, 1, 16'h001C, 2});
    tab.push_back('{0, 1, 16'h0040, 0, 16'h0000, 0, 16'h002C, 1, 16'h001C, 3});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 0});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0044, 0, 16'h0000, 0});
    tab.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0048, 1, 16'h0040, 1});
    tab.push_back('{0, 0, 16'h0000, 1, 16'h0100, 0, 16'h004C, 1, 16'h0040, 2});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 1, 16'h0040, 2});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0104, 1, 16'h0044, 1});
    tab.push_back('{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0108, 1, 16'h0100, 1});

    rst_n = 1'b0;
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkVal("reset_req",   64'(imem_req),  64'd0);
    checkVal("reset_addr",  64'(imem_addr), 64'd0);
    checkVal("reset_vld",   64'(dec_vld),   64'd0);
    checkVal("reset_pc",    64'(dec_pc),    64'd0);
    checkVal("reset_inst",  64'(dec_inst),  64'd0);
    checkVal("reset_count", 64'(q_count),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) begin
      applyStimulus(tab[i].rdy, tab[i].mis, tab[i].rec, tab[i].red, tab[i].rpc, 0, '0);
      checkOutput();
      checkVal($sformatf("tab%0d_req", i),   64'(imem_req),  64'(tab[i].eReq));
      checkVal($sformatf("tab%0d_addr", i),  64'(imem_addr), 64'(tab[i].eAddr));
      checkVal($sformatf("tab%0d_vld", i),   64'(dec_vld),   64'(tab[i].eVld));
      checkVal($sformatf("tab%0d_pc", i),    64'(dec_pc),    tab[i].eVld ? 64'(tab[i].ePc) : 64'd0);
      checkVal($sformatf("tab%0d_inst", i),  64'(dec_inst),  tab[i].eVld ? 64'(tagData(tab[i].ePc)) : 64'd0);
      checkVal($sformatf("tab%0d_count", i), 64'(q_count),   64'(tab[i].eCnt));
      advance();
    end

    // PC wrap past the top of the address space.
    runCycle(1, 0, '0, 1, 16'hFFFC, 0, '0);
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput();
    checkVal("wrap_first_addr", 64'(imem_addr), 64'hFFFC);
    advance();
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput();
    checkVal("wrap_next_addr", 64'(imem_addr), 64'h0000);
    advance();
    repeat (4) runCycle(1, 0, '0, 0, '0, 0, '0);

`ifdef FETCH_EXT_PC_EN
    runCycle(0, 1, 16'h0300, 0, '0, 1, 16'h0200);
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput();
    checkVal("ext_priority_addr", 64'(imem_addr), 64'h0200);
    advance();
    repeat (4) runCycle(1, 0, '0, 0, '0, 0, '0);
`endif

    // Mid-operation async reset with a request in flight.
    repeat (3) runCycle(0, 0, '0, 0, '0, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    checkVal("areset_req",   64'(imem_req),  64'd0);
    checkVal("areset_addr",  64'(imem_addr), 64'd0);
    checkVal("areset_vld",   64'(dec_vld),   64'd0);
    checkVal("areset_pc",    64'(dec_pc),    64'd0);
    checkVal("areset_count", 64'(q_count),   64'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) runCycle(1, 0, '0, 0, '0, 0, '0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bit              rdy, mis, red, ext;
      logic [PC_W-1:0] rec, rpc, epc;
      rdy = ($urandom_range(0, 9) < 7);
      mis = ($urandom_range(0, 99) < 3);
      red = ($urandom_range(0, 99) < 6);
      ext = ($urandom_range(0, 99) < 2);
      rec = 16'($urandom()) & 16'hFFFC;
      rpc = 16'($urandom()) & 16'hFFFC;
      epc = 16'($urandom()) & 16'hFFFC;
      runCycle(rdy, mis, rec, red, rpc, ext, epc);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised fetch front-end that generates FETCH_W-wide sequential fetch bundles, issues them to a fixed-latency instruction memory and buffers the returned bundles in a QDEPTH-entry queue. Decode drains the queue through a valid/ready handshake, so an instruction-memory access and a decode stall no longer have to line up in the same cycle. It sits between the PC-select logic and decode. It absorbs ROB misprediction recovery and front-end (branch/jump) redirects through a flush-and-epoch scheme.

## Interface
Parameters:
- PC_W, 16, PC and address width
- INST_W, 16, instruction width
- FETCH_W, 4, instructions per bundle (power of 2)
- QDEPTH, 4, queue depth in bundles (power of 2, ≥2)
- RESET_PC, 0, PC after reset

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- has_mispredict  in  1  ROB misprediction, flush everything
- pc_recovery  in  PC_W  restart PC on has_mispredict
- redirect_vld  in  1  front-end redirect (taken branch/jump)
- redirect_pc  in  PC_W  target for redirect_vld
- exter_pc_en  in  1  external PC load (FETCH_EXT_PC_EN only)
- exter_pc  in  PC_W  external PC (FETCH_EXT_PC_EN only)
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  bundle base address
- imem_rdata  in  FETCH_W*INST_W  bundle data, valid exactly 1 cycle after imem_req
- dec_vld  out  1  queue head valid
- dec_rdy  in  1  decode accepts head
- dec_pc  out  PC_W  base PC of head bundle
- dec_inst  out  FETCH_W*INST_W  head bundle, slot 0 in LSBs
- q_count  out  $clog2(QDEPTH+1)  occupied entries

## Operation
- pc register; imem_addr = pc (combinational). imem_req = credit_ok & ~flush.
- credit_ok = (q_count + inflight) < QDEPTH. A dequeue in the same cycle is not credited, which is conservative.
- On an issued request: pc <= pc + FETCH_W (mod 2^PC_W, wraps silently); inflight <= 1; inflight_epoch <= epoch.
- Response cycle: if inflight & (inflight_epoch == epoch) & ~flush, write {pc_of_req, imem_rdata} at the tail. Otherwise the response is dropped.
- Dequeue when dec_vld & dec_rdy. Enqueue and dequeue in the same cycle are legal at any occupancy.
- Flush sources, in priority order:
  - exter_pc_en (when compiled in), then has_mispredict: queue emptied (head=tail, count=0), epoch toggled, pc <= exter_pc / pc_recovery.
  - redirect_vld (when neither of the above is active): pc <= redirect_pc, epoch toggled (drops the in-flight response); queue contents retained.
- flush = any of the three sources. No request is issued in a flush cycle.
- No FSM beyond the queue pointers, inflight flag and epoch bit.

## Timing
- Reset values: pc=RESET_PC, imem_req=0 during reset, imem_addr=RESET_PC, dec_vld=0, dec_pc=0, dec_inst=0 (empty queue reads zero), q_count=0, epoch=0, inflight=0.
- Normal flow:
  - First request is in the first cycle after reset release.
  - Request at cycle t; rdata sampled at the end of t+1; dec_vld=1 from t+2.
- Redirect/mispredict sampled at edge e:
  - New pc visible after e; request issued in cycle e+1; dec_vld for the new target at e+3 at the earliest.
- Mispredict at the same edge as a dequeue: the flush wins and q_count = 0 afterwards.
- Redirect together with an in-flight response: the response is discarded and not enqueued.
- dec_rdy held low: the queue fills to QDEPTH and imem_req then stays 0. There is never an overflow and never more than one outstanding request.
- Async reset mid-operation clears everything immediately; an in-flight response is ignored.

## Configuration
- FETCH_EXT_PC_EN defined:
  - exter_pc and exter_pc_en ports exist.
  - exter_pc_en acts as the highest-priority full flush loading exter_pc. Used for test loading.
- Not defined: the ports are absent and the external-load path is removed. Priority becomes mispredict > redirect.

## Structure
- Shared package fetch_pkg holds:
  - default PC_W, INST_W and FETCH_W;
  - the bundle typedef (pc + FETCH_W instructions);
  - the flush-source encoding constants.
- One sub-module, fetch_bundle_fifo: parametrised QDEPTH FIFO with push, pop, flush, count, and head data output.
- PC, credit, epoch and flush logic stay in fetch_queue_unit.

## Test plan
- Reset release with dec_rdy=1 and memory returning addr-tagged data: dec_pc = 0, 4, 8, … one bundle per cycle, first dec_vld on the third cycle after reset release.
- Hold dec_rdy=0: q_count reaches 4, imem_req=0 while full. Raise dec_rdy: bundles 0, 4, 8, 12 drain in order with none lost or duplicated.
- Queue holding 3 bundles, has_mispredict with pc_recovery=0x0040: q_count=0 next cycle, next request addr 0x0040, first dec_pc=0x0040 three edges later.
- redirect_vld with redirect_pc=0x0100 while a request to 0x0010 is in flight: 0x0010 is never enqueued, older queued bundles are preserved, and 0x0100 follows them.
- pc=0xFFFC: next imem_addr=0x0000 (wrap).
- FETCH_EXT_PC_EN defined, exter_pc_en and has_mispredict asserted together: pc loads exter_pc, not pc_recovery.
